// File: rtl/dds_pkg.sv
// Shared DDS definitions: sample format, clock rate and frequency-meter FSM states.
package dds_pkg;

    localparam int unsigned CLK_HZ   = 100_000_000;
    localparam int unsigned SAMPLE_W = 14;
    localparam int unsigned MIDSCALE = 1 << (SAMPLE_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        GATE
    } meas_state_t;

endpackage

// File: rtl/dds_freq_meter_zc_detect.sv
// Rising zero-crossing detector with hysteresis on an offset-binary sample stream.
module zc_detect
    import dds_pkg::*;
#(
    parameter int unsigned SW       = SAMPLE_W,
    parameter int unsigned MIDSCALE = dds_pkg::MIDSCALE,
    parameter int unsigned HYST     = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] sample,
    output logic          zc
);

    // Thresholds are one bit wider than the sample so MIDSCALE+HYST cannot wrap.
    localparam logic [SW:0] LO_TH = (SW + 1)'(MIDSCALE - HYST);
    localparam logic [SW:0] HI_TH = (SW + 1)'(MIDSCALE + HYST);

    logic [SW-1:0] s_q;
    logic [SW:0]   s_ext;
    logic          lo_armed;

    assign s_ext = {1'b0, s_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= '0;
            lo_armed <= 1'b0;
            zc       <= 1'b0;
        end else begin
            s_q <= sample;
            zc  <= 1'b0;
            if (lo_armed && (s_ext >= HI_TH)) begin
                zc       <= 1'b1;
                lo_armed <= 1'b0;
            end else if (s_ext < LO_TH) begin
                lo_armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dds_freq_meter.sv
// Gated frequency and period meter for the DDS sine stream: counts rising
// zero crossings per gate and times the most recent cycle in clk ticks.
module dds_freq_meter
    import dds_pkg::*;
#(
    parameter int unsigned SW          = SAMPLE_W,
    parameter int unsigned FW          = 24,
    parameter int unsigned PW          = 32,
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned MIDSCALE    = dds_pkg::MIDSCALE,
    parameter int unsigned HYST        = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          meas_en,
    input  logic [SW-1:0] sample,
    output logic [FW-1:0] freq_out,
    output logic          freq_valid,
    output logic          freq_ovf,
    output logic [PW-1:0] period_out,
    output logic          period_valid,
    output logic          busy
);

    localparam int unsigned  GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    logic          zc;
    meas_state_t   state_q, state_d;
    logic          gate_done;
    logic [GW-1:0] gate_cnt;
    logic [FW-1:0] xcnt, xcnt_next;
    logic          ovf, ovf_next;
    logic          p_run;
    logic [PW-1:0] pcnt;

    zc_detect #(
        .SW       (SW),
        .MIDSCALE (MIDSCALE),
        .HYST     (HYST)
    ) u_zc (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample (sample),
        .zc     (zc)
    );

    always_comb begin
        state_d   = state_q;
        gate_done = 1'b0;
        case (state_q)
            IDLE: if (meas_en) state_d = ARM;
            ARM: begin
                if (!meas_en)  state_d = IDLE;
                else if (zc)   state_d = GATE;
            end
            GATE: begin
                if (!meas_en) state_d = IDLE;
                else          gate_done = (gate_cnt == GATE_LAST);
            end
            default: state_d = IDLE;
        endcase
    end

    // A crossing on the final gate clock is folded into the reported count.
    always_comb begin
        xcnt_next = xcnt;
        ovf_next  = ovf;
        if (zc) begin
            if (xcnt == '1) ovf_next  = 1'b1;
            else            xcnt_next = xcnt + 1'b1;
        end
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gate_cnt   <= '0;
            xcnt       <= '0;
            ovf        <= 1'b0;
            freq_out   <= '0;
            freq_ovf   <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            freq_valid <= 1'b0;
            if ((state_q == GATE) && meas_en) begin
                if (gate_done) begin
                    freq_out   <= xcnt_next;
                    freq_ovf   <= ovf_next;
                    freq_valid <= 1'b1;
                    gate_cnt   <= '0;
                    xcnt       <= '0;
                    ovf        <= 1'b0;
                end else begin
                    gate_cnt <= gate_cnt + 1'b1;
                    xcnt     <= xcnt_next;
                    ovf      <= ovf_next;
                end
            end else begin
                gate_cnt <= '0;
                xcnt     <= '0;
                ovf      <= 1'b0;
            end
        end
    end

    // Period tracking is independent of meas_en; the first crossing only starts pcnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_run        <= 1'b0;
            pcnt         <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (zc) begin
                p_run <= 1'b1;
                pcnt  <= '0;
                if (p_run) begin
                    period_out   <= (pcnt == '1) ? pcnt : pcnt + 1'b1;
                    period_valid <= 1'b1;
                end
            end else if (p_run && (pcnt != '1)) begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

endmodule
